// File: rtl/datapath_ctrl_fsm.sv
// Purpose : multi-cycle controller sequencing the datapath register enables for one latched instruction.
// Latency : s sampled in WAIT; w returns after 3 (MOV imm), 5 (MOV reg/MVN/CMP), 6 (ADD/AND), 2 (unsupported) edges.
// Backpr. : s is only honoured while w=1 (WAIT); it is ignored in every other state.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s, opcode, op     start strobe and instruction fields (instr[15:13], instr[12:11])
//   w                 ready for a new s (WAIT only)
//   nsel, vsel        regfile index select / write-data select
//   write             regfile write enable
//   loada..loads      A, B, C, status register load enables
//   asel, bsel        ALU operand selects (bsel reserved, always 0)
//   illegal           high while trapped in HALT
// Optional macro ILLEGAL_TRAP_EN: unsupported instructions park in HALT until reset
// instead of retiring silently.
module datapath_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_GET_A     = 3'd2;
    localparam logic [2:0] S_GET_B     = 3'd3;
    localparam logic [2:0] S_ALU       = 3'd4;
    localparam logic [2:0] S_WRITE_REG = 3'd5;
    localparam logic [2:0] S_WRITE_IMM = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [1:0] NSEL_RN = 2'd0;
    localparam logic [1:0] NSEL_RD = 2'd1;
    localparam logic [1:0] NSEL_RM = 2'd2;
    localparam logic [1:0] VSEL_C  = 2'd0;
    localparam logic [1:0] VSEL_IM = 2'd2;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] opcode_q;
    logic [1:0] op_q;

    // Decode of the latched instruction; live inputs never reach the outputs.
    logic is_mov_imm, is_mov_reg, is_mvn, is_add, is_cmp, is_and;
    assign is_mov_imm = ({opcode_q, op_q} == 5'b110_10);
    assign is_mov_reg = ({opcode_q, op_q} == 5'b110_00);
    assign is_mvn     = ({opcode_q, op_q} == 5'b101_11);
    assign is_add     = ({opcode_q, op_q} == 5'b101_00);
    assign is_cmp     = ({opcode_q, op_q} == 5'b101_01);
    assign is_and     = ({opcode_q, op_q} == 5'b101_10);

    // State register and instruction latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            opcode_q <= 3'd0;
            op_q     <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && s) begin
                opcode_q <= opcode;
                op_q     <= op;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_WAIT;
        case (state)
            S_WAIT:      state_nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (is_mov_imm)
                    state_nxt = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)
                    state_nxt = S_GET_B;   // single-operand ops skip the A load
                else if (is_add || is_cmp || is_and)
                    state_nxt = S_GET_A;
                else
`ifdef ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_WAIT;
`endif
            end
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_ALU;
            S_ALU:       state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nxt = S_WAIT;
            S_WRITE_IMM: state_nxt = S_WAIT;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:      state_nxt = S_HALT;
`endif
            // S_HALT without the trap, or any corrupted value, recovers to WAIT.
            default:     state_nxt = S_WAIT;
        endcase
    end

    // Moore output decode
    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_RN;
        vsel    = VSEL_C;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        illegal = 1'b0;
        case (state)
            S_WAIT:      w = 1'b1;
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                // A forced to 0 turns the ALU into a pass/invert of B.
                asel  = is_mov_reg || is_mvn;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IM;
                write = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT:      illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
